// File: rtl/sample_issue_ctrl.sv
// Sample issue sequencer: latches one triangle and its bounding box, then walks
// the box row-major, presenting SAMPS sample positions per cycle to sampletest.
// Upstream is held off for the whole walk; downstream stalls freeze the outputs.
module sample_issue_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
  input  logic [COLORS*SIGFIG-1:0]      color_R14U,
  input  logic [2*2*SIGFIG-1:0]         box_R14S,
  input  logic [SIGFIG-1:0]             step_R14U,
  input  logic                          validTri_R14H,
  output logic                          halt_RnnH,
  input  logic                          halt_R16H,
  output logic [VERTS*AXIS*SIGFIG-1:0]  tri_R16S,
  output logic [COLORS*SIGFIG-1:0]      color_R16U,
  output logic [2*SAMPS*SIGFIG-1:0]     sample_R16S,
  output logic [SAMPS-1:0]              validSamp_R16H,
  output logic                          lastVec_R16H
);

  // Two guard bits keep box-edge sums from wrapping.
  localparam int W = SIGFIG + 2;

  // The fraction width only defines how positions are interpreted; the walk
  // itself is pure signed fixed-point arithmetic and never needs it.
  localparam logic [31:0] FRAC_BITS = RADIX;
  logic unused_radix;
  assign unused_radix = ^FRAC_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, DONE = 2'd2} state_t;

  state_t state_reg, state_next;

  logic [VERTS*AXIS*SIGFIG-1:0] tri_reg;
  logic [COLORS*SIGFIG-1:0]     color_reg;
  logic signed [SIGFIG-1:0]     xmin_reg, ymin_reg, xmax_reg, ymax_reg;
  logic signed [SIGFIG-1:0]     x_cur_reg, y_cur_reg;
  logic [SIGFIG-1:0]            step_reg;

  logic signed [W-1:0] xmin_w, xmax_w, ymax_w, x_cur_w, y_cur_w, step_w;
  logic signed [W-1:0] vec_step, x_adv, y_adv;
  logic accept, degenerate, can_x, can_y, last_vec, consume;

  function automatic logic signed [W-1:0] sext(input logic [SIGFIG-1:0] v);
    return {{(W-SIGFIG){v[SIGFIG-1]}}, v};
  endfunction

  assign xmin_w   = sext(xmin_reg);
  assign xmax_w   = sext(xmax_reg);
  assign ymax_w   = sext(ymax_reg);
  assign x_cur_w  = sext(x_cur_reg);
  assign y_cur_w  = sext(y_cur_reg);
  assign step_w   = {{(W-SIGFIG){1'b0}}, step_reg};
  assign vec_step = W'(SAMPS) * step_w;
  assign x_adv    = x_cur_w + vec_step;
  assign y_adv    = y_cur_w + step_w;

  // An empty box still produces exactly one (all-invalid) vector so the walk terminates.
  assign degenerate = (xmax_reg < xmin_reg) || (ymax_reg < ymin_reg);
  assign can_x      = (x_adv <= xmax_w);
  assign can_y      = (y_adv <= ymax_w);
  assign last_vec   = degenerate || (!can_x && !can_y);

  // A new triangle may be taken whenever no walk is in flight, including the DONE cycle.
  assign accept  = validTri_R14H && (state_reg != WALK);
  assign consume = (state_reg == WALK) && !halt_R16H;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and upstream back-pressure.
  always_comb begin
    state_next = state_reg;
    halt_RnnH  = 1'b0;
    case (state_reg)
      IDLE: if (accept) state_next = WALK;
      WALK: begin
        halt_RnnH = 1'b1;
        if (consume && last_vec) state_next = DONE;
      end
      DONE: state_next = accept ? WALK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Triangle latch and walk position; position only moves when a vector is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_reg   <= '0;
      color_reg <= '0;
      xmin_reg  <= '0;
      ymin_reg  <= '0;
      xmax_reg  <= '0;
      ymax_reg  <= '0;
      step_reg  <= '0;
      x_cur_reg <= '0;
      y_cur_reg <= '0;
    end else if (accept) begin
      tri_reg   <= tri_R14S;
      color_reg <= color_R14U;
      xmin_reg  <= box_R14S[0*SIGFIG +: SIGFIG];
      ymin_reg  <= box_R14S[1*SIGFIG +: SIGFIG];
      xmax_reg  <= box_R14S[2*SIGFIG +: SIGFIG];
      ymax_reg  <= box_R14S[3*SIGFIG +: SIGFIG];
      step_reg  <= step_R14U;
      x_cur_reg <= box_R14S[0*SIGFIG +: SIGFIG];
      y_cur_reg <= box_R14S[1*SIGFIG +: SIGFIG];
    end else if (consume && !last_vec) begin
      if (can_x) begin
        x_cur_reg <= x_adv[SIGFIG-1:0];
      end else begin
        x_cur_reg <= xmin_reg;
        y_cur_reg <= y_adv[SIGFIG-1:0];
      end
    end
  end

  assign tri_R16S     = tri_reg;
  assign color_R16U   = color_reg;
  assign lastVec_R16H = (state_reg == WALK) && last_vec;

  genvar gi;
  generate
    for (gi = 0; gi < SAMPS; gi++) begin : g_lane
      logic signed [W-1:0] lane_x;
      assign lane_x = x_cur_w + W'(gi) * step_w;
      assign sample_R16S[(2*gi)*SIGFIG   +: SIGFIG] = lane_x[SIGFIG-1:0];
      assign sample_R16S[(2*gi+1)*SIGFIG +: SIGFIG] = y_cur_reg;
      assign validSamp_R16H[gi] = (state_reg == WALK) && !degenerate &&
                                  (lane_x <= xmax_w) && (y_cur_w <= ymax_w);
    end
  endgenerate

endmodule

// File: tb/tb_sample_issue_ctrl.sv
// Self-checking bench for sample_issue_ctrl: table of boxes with expected
// vector counts and first-vector masks, a scoreboard fed by a box-walk model,
// and hand-written stall, back-to-back and mid-walk reset sequences.
module tb_sample_issue_ctrl;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;
  localparam int TW = VERTS*AXIS*SIGFIG;
  localparam int CW = COLORS*SIGFIG;
  localparam int SW = 2*SAMPS*SIGFIG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [TW-1:0]        tri_R14S;
  logic [CW-1:0]        color_R14U;
  logic [4*SIGFIG-1:0]  box_R14S;
  logic [SIGFIG-1:0]    step_R14U;
  logic                 validTri_R14H;
  logic                 halt_RnnH;
  logic                 halt_R16H;
  logic [TW-1:0]        tri_R16S;
  logic [CW-1:0]        color_R16U;
  logic [SW-1:0]        sample_R16S;
  logic [SAMPS-1:0]     validSamp_R16H;
  logic                 lastVec_R16H;

  sample_issue_ctrl #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS),
                      .COLORS(COLORS), .SAMPS(SAMPS)) dut (
    .clk(clk), .rst(rst),
    .tri_R14S(tri_R14S), .color_R14U(color_R14U), .box_R14S(box_R14S),
    .step_R14U(step_R14U), .validTri_R14H(validTri_R14H), .halt_RnnH(halt_RnnH),
    .halt_R16H(halt_R16H), .tri_R16S(tri_R16S), .color_R16U(color_R16U),
    .sample_R16S(sample_R16S), .validSamp_R16H(validSamp_R16H),
    .lastVec_R16H(lastVec_R16H)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xmin; int ymin; int xmax; int ymax; int step;
    int exp_vecs;
    logic [SAMPS-1:0] exp_mask;   // bit 0 = lane 0
  } case_t;

  typedef struct {
    logic [SW-1:0]    samp;
    logic [SAMPS-1:0] mask;
    logic             last;
    logic [TW-1:0]    tri_v;
    logic [CW-1:0]    col;
  } vec_t;

  vec_t  q[$];
  case_t tbl[5];
  int    checks = 0;
  int    passed = 0;
  int    pops = 0;
  bit    present = 1'b0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] lanes(input longint x, input longint y, input longint st);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < SAMPS; k++) begin
      s[(2*k)*SIGFIG   +: SIGFIG] = SIGFIG'(x + longint'(k)*st);
      s[(2*k+1)*SIGFIG +: SIGFIG] = SIGFIG'(y);
    end
    return s;
  endfunction

  // Reference walk: every vector the DUT should present, in order.
  function automatic void model(input case_t c, input logic [TW-1:0] t, input logic [CW-1:0] col);
    vec_t e;
    e.tri_v = t;
    e.col   = col;
    e.last  = 1'b0;
    e.mask  = '0;
    if (c.xmax < c.xmin || c.ymax < c.ymin) begin
      e.samp = lanes(c.xmin, c.ymin, c.step);
      e.last = 1'b1;
      q.push_back(e);
      return;
    end
    for (longint y = c.ymin; y <= c.ymax; y += c.step) begin
      for (longint x = c.xmin; x <= c.xmax; x += SAMPS*c.step) begin
        e.samp = lanes(x, y, c.step);
        for (int k = 0; k < SAMPS; k++) e.mask[k] = (x + longint'(k)*c.step <= c.xmax);
        q.push_back(e);
      end
    end
    e = q[q.size()-1];
    e.last = 1'b1;
    q[q.size()-1] = e;
  endfunction

  // One clock: retire the vector shown last cycle if it was not stalled, then
  // compare what the DUT shows now against the scoreboard head.
  task automatic step();
    vec_t e;
    if (present && !halt_R16H && q.size() > 0) begin
      e = q.pop_front();
      pops++;
      $display("vec x0=%0d y=%0d mask=%b last=%b", $signed(e.samp[0 +: SIGFIG]),
               $signed(e.samp[SIGFIG +: SIGFIG]), e.mask, e.last);
    end
    @(negedge clk);
    present = halt_RnnH;
    if (present) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_vector: got mask %b expected no vector", validSamp_R16H);
      end else begin
        e = q[0];
        check("sample", TW'(sample_R16S), TW'(e.samp));
        check("valid_mask", TW'(validSamp_R16H), TW'(e.mask));
        check("last_vec", TW'(lastVec_R16H), TW'(e.last));
        check("tri_out", tri_R16S, e.tri_v);
        check("color_out", TW'(color_R16U), TW'(e.col));
      end
    end else begin
      check("idle_valid", TW'(validSamp_R16H), '0);
      check("idle_last", TW'(lastVec_R16H), '0);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < VERTS*AXIS; i++) tri_R14S[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    for (int i = 0; i < COLORS; i++) color_R14U[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    for (int i = 0; i < 4; i++) box_R14S[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    step_R14U = SIGFIG'($urandom);
  endtask

  // Offer a triangle; waits = cycles spent waiting for halt_RnnH to drop.
  task automatic offer(input case_t c, output int waits);
    logic [TW-1:0] t;
    logic [CW-1:0] col;
    for (int i = 0; i < VERTS*AXIS; i++) t[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    for (int i = 0; i < COLORS; i++) col[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    tri_R14S   = t;
    color_R14U = col;
    box_R14S   = {SIGFIG'(c.ymax), SIGFIG'(c.xmax), SIGFIG'(c.ymin), SIGFIG'(c.xmin)};
    step_R14U  = SIGFIG'(c.step);
    validTri_R14H = 1'b1;
    waits = 0;
    while (halt_RnnH && waits < 200) begin
      step();
      waits++;
    end
    if (halt_RnnH) begin
      checks++;
      $display("FAIL accept_timeout: got halt_RnnH=1 expected 0 within 200 cycles");
    end
    model(c, t, col);
    step();
    validTri_R14H = 1'b0;
    scramble();
  endtask

  // Run to the end of the walk; highs = cycles halt_RnnH was high.
  task automatic drain(output int highs);
    highs = 1;
    for (int n = 0; n < 500; n++) begin
      step();
      if (!halt_RnnH) break;
      highs++;
    end
    if (halt_RnnH) begin
      checks++;
      $display("FAIL drain_timeout: got halt_RnnH=1 expected 0 within 500 cycles");
    end
    step();
    check("queue_empty", TW'(q.size()), '0);
  endtask

  initial begin
    int w, h, p0;
    tbl[0] = '{xmin:0,     ymin:0,     xmax:5120,  ymax:1024, step:1024, exp_vecs:4, exp_mask:4'b1111};
    tbl[1] = '{xmin:2048,  ymin:2048,  xmax:2048,  ymax:2048, step:1024, exp_vecs:1, exp_mask:4'b0001};
    tbl[2] = '{xmin:0,     ymin:0,     xmax:-1024, ymax:1024, step:1024, exp_vecs:1, exp_mask:4'b0000};
    tbl[3] = '{xmin:-3072, ymin:-1024, xmax:-1024, ymax:0,    step:512,  exp_vecs:6, exp_mask:4'b1111};
    tbl[4] = '{xmin:0,     ymin:0,     xmax:0,     ymax:4096, step:2048, exp_vecs:3, exp_mask:4'b0001};

    validTri_R14H = 1'b0;
    halt_R16H     = 1'b0;
    scramble();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_halt", TW'(halt_RnnH), '0);
    check("rst_valid", TW'(validSamp_R16H), '0);
    check("rst_last", TW'(lastVec_R16H), '0);
    check("rst_sample", TW'(sample_R16S), '0);
    check("rst_tri", tri_R16S, '0);
    check("rst_color", TW'(color_R16U), '0);
    rst = 1'b0;
    step();

    // Table: box walks with expected vector count, busy cycles and first mask.
    for (int i = 0; i < 5; i++) begin
      p0 = pops;
      offer(tbl[i], w);
      check($sformatf("first_mask_%0d", i), TW'(validSamp_R16H), TW'(tbl[i].exp_mask));
      drain(h);
      check($sformatf("vec_count_%0d", i), TW'(pops - p0), TW'(tbl[i].exp_vecs));
      check($sformatf("busy_cycles_%0d", i), TW'(h), TW'(tbl[i].exp_vecs));
      $display("case %0d box x%0d..%0d y%0d..%0d vectors=%0d", i, tbl[i].xmin, tbl[i].xmax,
               tbl[i].ymin, tbl[i].ymax, pops - p0);
    end

    // Downstream stall on vector 2 for 3 cycles: held, nothing lost or repeated.
    p0 = pops;
    offer(tbl[0], w);
    step();
    halt_R16H = 1'b1;
    repeat (3) step();
    check("stall_hold_mask", TW'(validSamp_R16H), TW'(4'b0011));
    check("stall_hold_x", TW'(sample_R16S[0 +: SIGFIG]), TW'(4096));
    halt_R16H = 1'b0;
    drain(h);
    check("stall_vec_count", TW'(pops - p0), TW'(4));

    // Back-to-back: second triangle taken in the DONE cycle of the first.
    p0 = pops;
    offer(tbl[0], w);
    for (int n = 0; n < 20 && !lastVec_R16H; n++) step();
    check("b2b_last_seen", TW'(lastVec_R16H), TW'(1));
    offer(tbl[3], w);
    check("b2b_wait_cycles", TW'(w), TW'(1));
    drain(h);
    check("b2b_vec_count", TW'(pops - p0), TW'(10));

    // Reset in the middle of a walk, then a fresh walk from its own origin.
    offer(tbl[0], w);
    step();
    rst = 1'b1;
    q.delete();
    present = 1'b0;
    #1;
    check("midrst_halt", TW'(halt_RnnH), '0);
    check("midrst_valid", TW'(validSamp_R16H), '0);
    check("midrst_tri", tri_R16S, '0);
    step();
    rst = 1'b0;
    p0 = pops;
    offer(tbl[4], w);
    check("postrst_first_mask", TW'(validSamp_R16H), TW'(4'b0001));
    drain(h);
    check("postrst_vec_count", TW'(pops - p0), TW'(3));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
